// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: decodes CPU memory accesses onto RAM, LED and switch ports with a fixed 3-cycle handshake.
module mem_io_ctrl #(
  parameter logic [8:0] LED_ADDR = 9'h100,
  parameter logic [8:0] SW_ADDR  = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic [7:0]  ram_addr,
  output logic        ram_write,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {RG_RAM, RG_LED, RG_SW, RG_NONE} region_t;
  state_t state, next_state;
  region_t region, region_q;
  logic wr, wr_q, start;
  logic [7:0] sw_meta, sw_sync;
  always_comb begin
    wr = mem_cmd == 2'b10;
    start = (state == IDLE) & (wr | (mem_cmd == 2'b01));
    region = !mem_addr[8] ? RG_RAM : (mem_addr == LED_ADDR) ? RG_LED : (mem_addr == SW_ADDR) ? RG_SW : RG_NONE;
    next_state = start ? ACCESS : (state == ACCESS) ? DONE : IDLE;
  end
  assign ram_addr = mem_addr[7:0];
  assign ram_din = write_data;
  assign ram_write = start & wr & (region == RG_RAM) & ~reset;
  assign mem_ready = state == DONE;
  // RAM output is valid during ACCESS because the address was presented in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      region_q <= RG_RAM;
      wr_q <= 1'b0;
      read_data <= 16'h0000;
      led_out <= 8'h00;
      bus_err <= 1'b0;
      sw_meta <= 8'h00;
      sw_sync <= 8'h00;
    end else begin
      state <= next_state;
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      if (start) begin
        region_q <= region;
        wr_q <= wr;
        if (wr && region == RG_LED) led_out <= write_data[7:0];
        if (wr && (region == RG_SW || region == RG_NONE)) bus_err <= 1'b1;
      end
      if (state == ACCESS && !wr_q) begin
        read_data <= (region_q == RG_RAM) ? ram_dout :
                     (region_q == RG_LED) ? {8'h00, led_out} :
                     (region_q == RG_SW)  ? {8'h00, sw_sync} : 16'h0000;
        if (region_q == RG_NONE) bus_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: vector table plus corner sequences, with a read-data scoreboard and a behavioural RAM.
module tb_mem_io_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] mem_cmd = 2'b00;
  logic [8:0] mem_addr = 9'h000;
  logic [15:0] write_data = 16'h0000, read_data, ram_din, ram_dout;
  logic mem_ready, ram_write, bus_err;
  logic [7:0] ram_addr, led_out, sw_in = 8'h00;
  logic [15:0] ram_m [256];
  logic [15:0] sb [$];
  int checks = 0, errors = 0;
  typedef struct {logic [1:0] cmd; logic [8:0] addr; logic [15:0] wd; logic [15:0] rd; logic [7:0] led; logic err;} vec_t;
  vec_t vecs [11];
  mem_io_ctrl dut (.clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
    .read_data(read_data), .mem_ready(mem_ready), .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din),
    .ram_dout(ram_dout), .sw_in(sw_in), .led_out(led_out), .bus_err(bus_err));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_write) ram_m[ram_addr] <= ram_din;
    ram_dout <= ram_m[ram_addr];
  end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic access(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                        input logic [15:0] rd, input logic [7:0] led, input logic err);
    int n;
    @(negedge clk);
    mem_cmd = cmd; mem_addr = addr; write_data = wd;
    sb.push_back(rd);
    #1 chk("ram_write_T", 16'(ram_write), 16'(cmd == 2'b10 && !addr[8]));
    @(posedge clk);
    #1 chk("led_T1", 16'(led_out), 16'(led));
    chk("ram_write_T1", 16'(ram_write), 16'h0);
    chk("ready_T1", 16'(mem_ready), 16'h0);
    n = 1;
    while (!mem_ready && n < 6) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 16'(n), 16'd2);
    chk("read_data", read_data, sb.pop_front());
    chk("bus_err", 16'(bus_err), 16'(err));
    mem_cmd = 2'b00;
    @(posedge clk);
    #1 chk("ready_once", 16'(mem_ready), 16'h0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram_m[i] = 16'h0000;
    vecs[0]  = '{2'b10, 9'h006, 16'hABCD, 16'h0000, 8'h00, 1'b0};
    vecs[1]  = '{2'b01, 9'h006, 16'h0000, 16'hABCD, 8'h00, 1'b0};
    vecs[2]  = '{2'b10, 9'h100, 16'h12A5, 16'hABCD, 8'hA5, 1'b0};
    vecs[3]  = '{2'b01, 9'h100, 16'h0000, 16'h00A5, 8'hA5, 1'b0};
    vecs[4]  = '{2'b10, 9'h005, 16'h1234, 16'h00A5, 8'hA5, 1'b0};
    vecs[5]  = '{2'b01, 9'h005, 16'h0000, 16'h1234, 8'hA5, 1'b0};
    vecs[6]  = '{2'b10, 9'h0FF, 16'h5A5A, 16'h1234, 8'hA5, 1'b0};
    vecs[7]  = '{2'b01, 9'h0FF, 16'h0000, 16'h5A5A, 8'hA5, 1'b0};
    vecs[8]  = '{2'b10, 9'h1FF, 16'hFFFF, 16'h5A5A, 8'hA5, 1'b1};
    vecs[9]  = '{2'b01, 9'h120, 16'h0000, 16'h0000, 8'hA5, 1'b1};
    vecs[10] = '{2'b01, 9'h006, 16'h0000, 16'hABCD, 8'hA5, 1'b1};
    repeat (2) @(posedge clk);
    #1 chk("rst_ready", 16'(mem_ready), 16'h0);
    chk("rst_read_data", read_data, 16'h0000);
    chk("rst_led", 16'(led_out), 16'h0);
    chk("rst_bus_err", 16'(bus_err), 16'h0);
    @(negedge clk) reset = 1'b0;
    foreach (vecs[i]) access(vecs[i].cmd, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].led, vecs[i].err);
    sw_in = 8'h3C;
    access(2'b01, 9'h140, 16'h0000, 16'h0000, 8'hA5, 1'b1);
    access(2'b01, 9'h140, 16'h0000, 16'h003C, 8'hA5, 1'b1);
    access(2'b10, 9'h140, 16'h00FF, 16'h003C, 8'hA5, 1'b1);
    access(2'b01, 9'h006, 16'h0000, 16'hABCD, 8'hA5, 1'b1);
    @(negedge clk);
    mem_cmd = 2'b01; mem_addr = 9'h005;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; mem_cmd = 2'b00;
    @(posedge clk);
    #1 chk("mid_rst_ready", 16'(mem_ready), 16'h0);
    chk("mid_rst_read_data", read_data, 16'h0000);
    chk("mid_rst_bus_err", 16'(bus_err), 16'h0);
    chk("mid_rst_led", 16'(led_out), 16'h0);
    @(negedge clk) reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 chk("post_rst_ready", 16'(mem_ready), 16'h0);
    end
    @(negedge clk);
    mem_cmd = 2'b10; mem_addr = 9'h008; write_data = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; mem_cmd = 2'b00;
    @(posedge clk);
    @(negedge clk);
    mem_cmd = 2'b10; mem_addr = 9'h007; write_data = 16'hDEAD;
    #1 chk("rst_write_suppressed", 16'(ram_write), 16'h0);
    @(posedge clk);
    #1 mem_cmd = 2'b00;
    @(negedge clk) reset = 1'b0;
    access(2'b01, 9'h008, 16'h0000, 16'hBEEF, 8'h00, 1'b0);
    access(2'b01, 9'h007, 16'h0000, 16'h0000, 8'h00, 1'b0);
    chk("sb_empty", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
